// File: rtl/uart_tx_cfg_if.sv
// Character handshake between a byte source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, 1-2 stop bits).
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_tx_cfg_if.slave  tx,
`ifdef UART_TX_BREAK_EN
  input  logic          tx_break,
`endif
  output logic          serial_tx,
  output logic          busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_TX_BREAK_EN
    S_BREAK,
`endif
    S_STOP
  } state_t;

  // Odd mode inverts the XOR so the total count of ones on the line is odd.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  state_t               state, state_nx;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_nx;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
  logic                 stop_cnt, stop_cnt_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 par_bit, par_bit_nx;
  logic                 line_nx;
  logic                 ready;
  logic                 accept;
  logic                 bit_end;
  logic                 brk;

`ifdef UART_TX_BREAK_EN
  assign brk   = tx_break;
  assign ready = (state == S_IDLE) && !tx_break;
`else
  assign brk   = 1'b0;
  assign ready = (state == S_IDLE);
`endif

  assign tx.tx_ready = ready;
  assign accept      = tx.tx_valid && ready;
  assign bit_end     = (baud_cnt == CNT_W'(CPB - 1));

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_nx  = bit_idx;
    stop_cnt_nx = stop_cnt;
    shift_nx    = shift;
    par_bit_nx  = par_bit;
    line_nx     = 1'b1;

    case (state)
      S_IDLE: begin
        baud_cnt_nx = '0;
        bit_idx_nx  = '0;
        stop_cnt_nx = 1'b0;
        if (brk) begin
`ifdef UART_TX_BREAK_EN
          state_nx = S_BREAK;
`endif
        end else if (accept) begin
          state_nx   = S_START;
          shift_nx   = tx.tx_data;
          par_bit_nx = calc_parity(tx.tx_data);
        end
      end
      S_START: if (bit_end) state_nx = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_nx = shift >> 1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_nx = '0;
            state_nx   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nx = bit_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            stop_cnt_nx = 1'b0;
            state_nx    = S_IDLE;
`ifdef UART_TX_BREAK_EN
            if (brk) state_nx = S_BREAK;
`endif
          end else begin
            stop_cnt_nx = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // Counter parked at zero so the release stop period is a full one.
      S_BREAK: begin
        baud_cnt_nx = '0;
        if (!brk) state_nx = S_STOP;
      end
`endif
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_START:  line_nx = 1'b0;
      S_DATA:   line_nx = shift_nx[0];
      S_PARITY: line_nx = par_bit_nx;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  line_nx = 1'b0;
`endif
      default:  line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      par_bit   <= 1'b0;
      serial_tx <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_cnt_nx;
      bit_idx   <= bit_idx_nx;
      stop_cnt  <= stop_cnt_nx;
      shift     <= shift_nx;
      par_bit   <= par_bit_nx;
      serial_tx <= line_nx;
      busy      <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations (8N1, 7E2, 8O1) at 4 clocks per bit.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic brk = 1'b0;
  logic brk_off = 1'b0;
  logic st1, st2, st3, bz1, bz2, bz3;
  int   sel = 1;
  logic cur_line, cur_busy, cur_ready;
  int   tests = 0;
  int   fails = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if3 ();

  uart_tx_cfg #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .tx(if1),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk),
`endif
    .serial_tx(st1), .busy(bz1));

  uart_tx_cfg #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .tx(if2),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_off),
`endif
    .serial_tx(st2), .busy(bz2));

  uart_tx_cfg #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .reset_n(reset_n), .tx(if3),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk_off),
`endif
    .serial_tx(st3), .busy(bz3));

  always_comb begin
    cur_line  = st1;
    cur_busy  = bz1;
    cur_ready = if1.tx_ready;
    case (sel)
      2: begin cur_line = st2; cur_busy = bz2; cur_ready = if2.tx_ready; end
      3: begin cur_line = st3; cur_busy = bz3; cur_ready = if3.tx_ready; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic [8:0] d, input logic v);
    case (s)
      2:       begin if2.tx_data = d[6:0]; if2.tx_valid = v; end
      3:       begin if3.tx_data = d[7:0]; if3.tx_valid = v; end
      default: begin if1.tx_data = d[7:0]; if1.tx_valid = v; end
    endcase
  endtask

  function automatic logic model_par(input logic [8:0] d, input int nb, input int mode);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return (mode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic push_frame(input logic [8:0] d, input int nb, input int par, input int st);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) exp_q.push_back(d[i]);
    if (par != 0) exp_q.push_back(model_par(d, nb, par));
    for (int i = 0; i < st; i++) exp_q.push_back(1'b1);
  endtask

  // Entered at the negedge of frame cycle 0; leaves at the negedge of cycle f.
  task automatic sample_frame(input int f, input string tag);
    int  bcnt = 0;
    int  rcnt = 0;
    logic e;
    for (int c = 0; c < f; c++) begin
      if (cur_busy === 1'b1) bcnt++;
      if (cur_ready === 1'b0) rcnt++;
      if (c % 4 == 2) begin
        if (exp_q.size() == 0) begin
          check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_bit%0d", tag, c / 4), 32'(cur_line), 32'(e));
        end
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(f));
    check({tag, "_notready_cycles"}, 32'(rcnt), 32'(f));
    check({tag, "_end_line"}, 32'(cur_line), 32'd1);
    check({tag, "_end_busy"}, 32'(cur_busy), 32'd0);
  endtask

  task automatic run_frame(input int s, input logic [8:0] d, input int nb, input int par,
                           input int st, input string tag);
    int f;
    f   = 4 * (1 + nb + ((par != 0) ? 1 : 0) + st);
    sel = s;
    push_frame(d, nb, par, st);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(cur_ready), 32'd1);
    drive(s, d, 1'b1);
    @(negedge clk);
    drive(s, ~d, 1'b0);
    sample_frame(f, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 9'h0, 1'b0);
    drive(2, 9'h0, 1'b0);
    drive(3, 9'h0, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset_line_%0d", s), 32'(cur_line), 32'd1);
      check($sformatf("reset_busy_%0d", s), 32'(cur_busy), 32'd0);
      check($sformatf("reset_ready_%0d", s), 32'(cur_ready), 32'd1);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // 8N1 basic frame
    run_frame(1, 9'h0A5, 8, 0, 1, "t1_a5");

    // 7E2 frame
    run_frame(2, 9'h055, 7, 2, 2, "t2_55");

    // odd parity corner values
    run_frame(3, 9'h000, 8, 1, 1, "t3_00");
    run_frame(3, 9'h0FF, 8, 1, 1, "t3_ff");
    run_frame(3, 9'h001, 8, 1, 1, "t3_01");

    // back-to-back with tx_valid held high
    sel = 1;
    @(negedge clk);
    push_frame(9'h03C, 8, 0, 1);
    push_frame(9'h0C3, 8, 0, 1);
    drive(1, 9'h03C, 1'b1);
    @(negedge clk);
    drive(1, 9'h0C3, 1'b1);
    sample_frame(40, "t4_3c");
    check("t4_gap_ready", 32'(cur_ready), 32'd1);
    @(negedge clk);
    check("t4_second_start", 32'(cur_line), 32'd0);
    drive(1, 9'h000, 1'b0);
    sample_frame(40, "t4_c3");

    // reset during data bit 3 of 0xF0
    drive(1, 9'h0F0, 1'b1);
    @(negedge clk);
    drive(1, 9'h000, 1'b0);
    repeat (17) @(negedge clk);
    check("t5_pre_bit3", 32'(cur_line), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_rst_line", 32'(cur_line), 32'd1);
    check("t5_rst_busy", 32'(cur_busy), 32'd0);
    check("t5_rst_ready", 32'(cur_ready), 32'd1);
    reset_n = 1'b1;
    run_frame(1, 9'h081, 8, 0, 1, "t5_81");

`ifdef UART_TX_BREAK_EN
    begin
      int lows = 0;
      int highs = 0;
      sel = 1;
      @(negedge clk);
      push_frame(9'h05A, 8, 0, 1);
      drive(1, 9'h05A, 1'b1);
      brk = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (cur_line === 1'b0 && cur_ready === 1'b0 && cur_busy === 1'b1) lows++;
      end
      brk = 1'b0;
      check("t6_break_low_cycles", 32'(lows), 32'd30);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (cur_line === 1'b1 && cur_ready === 1'b0 && cur_busy === 1'b1) highs++;
      end
      check("t6_stop_high_cycles", 32'(highs), 32'd4);
      @(negedge clk);
      check("t6_idle_line", 32'(cur_line), 32'd1);
      check("t6_idle_ready", 32'(cur_ready), 32'd1);
      @(negedge clk);
      drive(1, 9'h000, 1'b0);
      sample_frame(40, "t6_5a");
    end
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
